// File: rtl/sal_ref_ctrl.sv
// sal_ref_ctrl: auto-refresh request generator for a channel of bank controllers.
// Counts tREFI intervals, hands out one refresh obligation per tick and tracks
// postponed refreshes per bank up to MAX_POSTPONE, with a sticky overflow error.
// Build option: define SAL_REF_ALLBANK_EN for all-bank mode, where every tick
// targets every bank at once and no round-robin pointer exists.

// Per-bank pending-refresh tracker.
module sal_ref_bank #(
  parameter int MAX_POSTPONE = 8,
  parameter int PEND_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic gnt,
  output logic req,
  output logic urgent,
  output logic ovf
);
  localparam logic [PEND_W-1:0] PMAX = PEND_W'(MAX_POSTPONE);

  logic [PEND_W-1:0] pend;
  logic              valid;

  // A grant only counts while something is owed; this is what prevents underflow.
  assign valid  = gnt && (pend != '0);
  assign ovf    = tick && !valid && (pend == PMAX);
  assign req    = (pend != '0);
  assign urgent = (pend == PMAX);

  // Pending count: tick adds, valid grant retires, both together cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (tick && !valid && (pend != PMAX)) begin
      pend <= pend + PEND_W'(1);
    end else if (valid && !tick) begin
      pend <= pend - PEND_W'(1);
    end
  end
endmodule

module sal_ref_ctrl #(
  parameter int NUM_BANKS    = 4,
  parameter int MAX_POSTPONE = 8,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_W-1:0]     refi_i,
  output logic [NUM_BANKS-1:0] ref_req_o,
  input  logic [NUM_BANKS-1:0] ref_gnt_i,
  output logic [NUM_BANKS-1:0] ref_urgent_o,
  output logic                 err_o
);
  localparam int PEND_W = $clog2(MAX_POSTPONE + 1);

  logic [CNT_W-1:0]     cnt;
  logic                 tick;
  logic [NUM_BANKS-1:0] tgt;
  logic [NUM_BANKS-1:0] ovf;

  // >= rather than == so that lowering refi_i mid-interval still ticks promptly.
  assign tick = (refi_i != '0) && (cnt >= refi_i - CNT_W'(1));

  // Interval counter; held at 0 while generation is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (refi_i == '0 || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef SAL_REF_ALLBANK_EN
  assign tgt = {NUM_BANKS{tick}};
`else
  localparam int PTR_W = $clog2(NUM_BANKS);

  logic [PTR_W-1:0] ptr;

  // Round-robin target pointer; NUM_BANKS is a power of two so it wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (tick) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_tgt
    assign tgt[b] = tick && (ptr == PTR_W'(b));
  end
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sal_ref_bank #(
      .MAX_POSTPONE (MAX_POSTPONE),
      .PEND_W       (PEND_W)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tgt[b]),
      .gnt    (ref_gnt_i[b]),
      .req    (ref_req_o[b]),
      .urgent (ref_urgent_o[b]),
      .ovf    (ovf[b])
    );
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (|ovf) begin
      err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sal_ref_ctrl.sv
// Self-checking bench for sal_ref_ctrl (NUM_BANKS=4, MAX_POSTPONE=8).
// Honours SAL_REF_ALLBANK_EN the same way as the design.
module tb_sal_ref_ctrl;
  localparam int NB   = 4;
  localparam int MAXP = 8;
`ifdef SAL_REF_ALLBANK_EN
  localparam bit ALL = 1'b1;
`else
  localparam bit ALL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   refi = '0;
  logic [NB-1:0] gnt = '0;
  logic [NB-1:0] req, urg;
  logic          err;

  int checks = 0;
  int errors = 0;

  // Reference model state: obligations owed per bank, cycles since last tick.
  int m_pend[NB];
  int m_cnt;
  int m_ptr;
  bit m_err;

  sal_ref_ctrl #(.NUM_BANKS(NB), .MAX_POSTPONE(MAXP), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .refi_i       (refi),
    .ref_req_o    (req),
    .ref_gnt_i    (gnt),
    .ref_urgent_o (urg),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] m_req();
    logic [NB-1:0] r;
    for (int b = 0; b < NB; b++) r[b] = (m_pend[b] != 0);
    return r;
  endfunction

  function automatic logic [NB-1:0] m_urg();
    logic [NB-1:0] r;
    for (int b = 0; b < NB; b++) r[b] = (m_pend[b] == MAXP);
    return r;
  endfunction

  task automatic m_reset();
    for (int b = 0; b < NB; b++) m_pend[b] = 0;
    m_cnt = 0;
    m_ptr = 0;
    m_err = 0;
  endtask

  // One clock of the model from the rules: a tick every refi cycles, owed count
  // per bank, grants retire only what is owed, overflow is sticky.
  task automatic m_step(input int r, input logic [NB-1:0] g);
    bit t;
    t = (r != 0) && (m_cnt + 1 >= r);
    m_cnt = (r == 0 || t) ? 0 : m_cnt + 1;
    for (int b = 0; b < NB; b++) begin
      bit hit, ok;
      hit = t && (ALL || b == m_ptr);
      ok  = g[b] && m_pend[b] > 0;
      if (hit && !ok) begin
        if (m_pend[b] == MAXP) m_err = 1;
        else m_pend[b]++;
      end else if (ok && !hit) begin
        m_pend[b]--;
      end
    end
    if (t && !ALL) m_ptr = (m_ptr + 1) % NB;
  endtask

  // Drive inputs, advance the model, then sample 1 time unit after the edge.
  task automatic step(input logic [15:0] r, input logic [NB-1:0] g);
    refi = r;
    gnt  = g;
    m_step(int'(r), g);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [15:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    refi  = '0;
    gnt   = '0;
    m_reset();
    @(posedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_urg", urg, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0]   refi;
    logic [NB-1:0] gnt;
    int            n;
    logic [NB-1:0] req;
    logic [NB-1:0] urg;
    logic          err;
  } vec_t;

  vec_t tbl[8];
  int   ntbl;

  initial begin
    logic [NB-1:0] first;
    int fill, dens;
    logic [NB-1:0] g;
    logic [15:0] r;

`ifdef SAL_REF_ALLBANK_EN
    tbl[0] = '{16'd10, 4'h0, 8, 4'h0, 4'h0, 1'b0};
    tbl[1] = '{16'd10, 4'h0, 1, 4'h0, 4'h0, 1'b0};
    tbl[2] = '{16'd10, 4'h0, 1, 4'hF, 4'h0, 1'b0};
    tbl[3] = '{16'd10, 4'hF, 1, 4'h0, 4'h0, 1'b0};
    tbl[4] = '{16'd10, 4'h0, 8, 4'h0, 4'h0, 1'b0};
    tbl[5] = '{16'd10, 4'h0, 1, 4'hF, 4'h0, 1'b0};
    ntbl = 6;
    first = 4'hF;
    fill  = MAXP;
`else
    tbl[0] = '{16'd10, 4'h0, 9,  4'h0, 4'h0, 1'b0};
    tbl[1] = '{16'd10, 4'h0, 1,  4'h1, 4'h0, 1'b0};
    tbl[2] = '{16'd10, 4'h0, 10, 4'h3, 4'h0, 1'b0};
    tbl[3] = '{16'd10, 4'h0, 10, 4'h7, 4'h0, 1'b0};
    tbl[4] = '{16'd10, 4'h0, 10, 4'hF, 4'h0, 1'b0};
    tbl[5] = '{16'd10, 4'h0, 10, 4'hF, 4'h0, 1'b0};
    tbl[6] = '{16'd10, 4'hF, 1,  4'h1, 4'h0, 1'b0};
    tbl[7] = '{16'd10, 4'h0, 9,  4'h3, 4'h0, 1'b0};
    ntbl = 8;
    first = 4'h1;
    fill  = NB * MAXP;
`endif

    // Basic tick order, wrap and grant retire from the vector table.
    do_reset();
    for (int i = 0; i < ntbl; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].refi, tbl[i].gnt);
      chk($sformatf("tbl%0d_req", i), req, tbl[i].req);
      chk($sformatf("tbl%0d_urg", i), urg, tbl[i].urg);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
    end

    // Simultaneous tick and grant on bank 0 at pend==3 leaves it at 3.
    do_reset();
    run(16'd1, ALL ? 3 : 3 * NB);
    step(16'd1, 4'h1);
    chk("simul_req", req, 4'hF);
    chk("simul_err", err, 0);
    step(16'd0, 4'h1);
    step(16'd0, 4'h1);
    chk("simul_g2_req", req, 4'hF);
    step(16'd0, 4'h1);
    chk("simul_g3_req", req, 4'hE);

    // Saturation, sticky error, asynchronous reset clear.
    do_reset();
    run(16'd1, fill - 1);
    chk("sat_pre_urg", urg, ALL ? 4'h0 : 4'h7);
    run(16'd1, 1);
    chk("sat_urg", urg, 4'hF);
    chk("sat_err0", err, 0);
    run(16'd1, 1);
    chk("sat_err1", err, 1);
    chk("sat_hold_urg", urg, 4'hF);
    step(16'd0, 4'hF);
    chk("sat_gnt_req", req, 4'hF);
    chk("sat_gnt_urg", urg, 4'h0);
    chk("sat_gnt_err", err, 1);
    run(16'd0, 3);
    chk("sat_sticky_err", err, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_err", err, 0);
    chk("async_rst_req", req, 0);

    // Spurious grants, disable mid-interval, restore.
    do_reset();
    step(16'd0, 4'hF);
    step(16'd0, 4'hF);
    chk("spur_req", req, 0);
    chk("spur_urg", urg, 0);
    run(16'd5, 3);
    run(16'd0, 20);
    chk("dis_req", req, 0);
    run(16'd5, 4);
    chk("restore_pre_req", req, 0);
    run(16'd5, 1);
    chk("restore_req", req, first);

    // Randomized traffic against the model.
    do_reset();
    r = 16'd3;
    dens = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        r    = 16'($urandom_range(0, 6));
        dens = $urandom_range(0, 8);
      end
      g = '0;
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 7) < dens) g[b] = 1'b1;
      if ($urandom_range(0, 7) != 0) g = g & m_req();
      step(r, g);
      chk("rand_req", req, m_req());
      chk("rand_urg", urg, m_urg());
      chk("rand_err", err, m_err);
      if (m_err && $urandom_range(0, 99) == 0) begin
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
